// File: rtl/skid_pkg.sv
// Shared types for the two-entry skid register slice.
// The state encoding doubles as the occupancy count.
package skid_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/width_adapt.sv
// Combinational width adapter: sign/zero extension or truncation.
// Also used standalone by the downstream register stage.
module width_adapt #(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 5,
  parameter bit SIGNED    = 1'b1
) (
  input  logic [IN_WIDTH-1:0]  word,
  output logic [OUT_WIDTH-1:0] adapted
);

  generate
    if (OUT_WIDTH > IN_WIDTH) begin : g_ext
      logic ext;
      assign ext     = SIGNED & word[IN_WIDTH-1];
      assign adapted = {{(OUT_WIDTH-IN_WIDTH){ext}}, word};
    end else if (OUT_WIDTH == IN_WIDTH) begin : g_pass
      assign adapted = word;
    end else begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^word[IN_WIDTH-1:OUT_WIDTH];
      assign adapted   = word[OUT_WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/skid_reg_slice.sv
// Two-entry ready/valid skid buffer with registered output and
// width adaptation on capture; in_ready depends only on state.
module skid_reg_slice
  import skid_pkg::*;
#(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 5,
  parameter bit SIGNED    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [OCC_W-1:0]     occupancy
);

  skid_state_t          state_q;
  skid_state_t          state_d;
  logic [OUT_WIDTH-1:0] out_q;
  logic [OUT_WIDTH-1:0] skid_q;
  logic [OUT_WIDTH-1:0] adapted;
  logic                 accept;
  logic                 deliver;
  logic                 load_in;
  logic                 load_skid;
  logic                 pop_skid;

  width_adapt #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SIGNED   (SIGNED)
  ) u_adapt (
    .word   (in_data),
    .adapted(adapted)
  );

  assign in_ready  = !rst && !clear
                  && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_q;
  assign occupancy = state_q;
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    load_in   = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    if (clear) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            load_in = 1'b1;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (accept && deliver) begin
            load_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (deliver) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            pop_skid = 1'b1;
            state_d  = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_in)
        out_q <= adapted;
      else if (pop_skid)
        out_q <= skid_q;
      if (load_skid)
        skid_q <= adapted;
    end
  end

endmodule

// File: tb/tb_skid_reg_slice.sv
// Directed bench for skid_reg_slice: vector table plus
// clear/reset corner sequences; signed and unsigned instances.
module tb_skid_reg_slice;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_data = 2'b00;
  logic       out_ready = 1'b0;
  logic       in_ready, in_ready_u;
  logic       out_valid, out_valid_u;
  logic [4:0] out_data, out_data_u;
  logic [1:0] occupancy, occupancy_u;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  skid_reg_slice #(.IN_WIDTH(2), .OUT_WIDTH(5), .SIGNED(1'b1)) u_dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy)
  );

  skid_reg_slice #(.IN_WIDTH(2), .OUT_WIDTH(5), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
    .out_valid(out_valid_u), .out_ready(out_ready),
    .out_data(out_data_u), .occupancy(occupancy_u)
  );

  typedef struct {
    logic       rst, clr, iv;
    logic [1:0] id;
    logic       ordy;
    logic       chk;
    logic       ev;
    logic [4:0] ed;
    logic [1:0] eo;
    logic       er;
    logic       cd;
    logic       cu;
    logic [4:0] eu;
  } vec_t;

  vec_t vt[19];

  function automatic vec_t v(
    logic r, logic c, logic iv, logic [1:0] id, logic ordy,
    logic chk, logic ev, logic [4:0] ed, logic [1:0] eo,
    logic er, logic cd, logic cu, logic [4:0] eu);
    vec_t x;
    x.rst = r; x.clr = c; x.iv = iv; x.id = id; x.ordy = ordy;
    x.chk = chk; x.ev = ev; x.ed = ed; x.eo = eo; x.er = er;
    x.cd = cd; x.cu = cu; x.eu = eu;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic c, logic iv,
                       logic [1:0] id, logic ordy);
    @(negedge clk);
    rst = r; clear = c; in_valid = iv;
    in_data = id; out_ready = ordy;
    #1;
  endtask

  initial begin
    // Outputs are checked during each row's cycle, before its edge.
    vt[0]  = v(1,0,0,2'b00,0, 0, 0,5'b00000,0,0, 0, 0,5'b00000);
    vt[1]  = v(1,0,0,2'b00,0, 1, 0,5'b00000,0,0, 1, 1,5'b00000);
    vt[2]  = v(0,0,1,2'b10,1, 1, 0,5'b00000,0,1, 1, 0,5'b00000);
    vt[3]  = v(0,0,0,2'b00,1, 1, 1,5'b11110,1,1, 1, 1,5'b00010);
    vt[4]  = v(0,0,1,2'b01,1, 1, 0,5'b11110,0,1, 1, 1,5'b00010);
    vt[5]  = v(0,0,0,2'b00,0, 1, 1,5'b00001,1,1, 1, 1,5'b00001);
    vt[6]  = v(0,0,0,2'b00,1, 1, 1,5'b00001,1,1, 1, 0,5'b00000);
    vt[7]  = v(0,0,1,2'b01,0, 1, 0,5'b00000,0,1, 0, 0,5'b00000);
    vt[8]  = v(0,0,1,2'b11,0, 1, 1,5'b00001,1,1, 1, 0,5'b00000);
    vt[9]  = v(0,0,1,2'b00,0, 1, 1,5'b00001,2,0, 1, 0,5'b00000);
    vt[10] = v(0,0,0,2'b00,1, 1, 1,5'b00001,2,0, 1, 0,5'b00000);
    vt[11] = v(0,0,0,2'b00,1, 1, 1,5'b11111,1,1, 1, 1,5'b00011);
    vt[12] = v(0,0,0,2'b00,0, 1, 0,5'b00000,0,1, 0, 0,5'b00000);
    vt[13] = v(0,0,1,2'b00,1, 1, 0,5'b00000,0,1, 0, 0,5'b00000);
    vt[14] = v(0,0,1,2'b01,1, 1, 1,5'b00000,1,1, 1, 1,5'b00000);
    vt[15] = v(0,0,1,2'b10,1, 1, 1,5'b00001,1,1, 1, 1,5'b00001);
    vt[16] = v(0,0,1,2'b11,1, 1, 1,5'b11110,1,1, 1, 1,5'b00010);
    vt[17] = v(0,0,0,2'b00,1, 1, 1,5'b11111,1,1, 1, 1,5'b00011);
    vt[18] = v(0,0,0,2'b00,1, 1, 0,5'b00000,0,1, 0, 0,5'b00000);

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].rst, vt[i].clr, vt[i].iv, vt[i].id, vt[i].ordy);
      if (vt[i].chk) begin
        chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vt[i].ev));
        chk($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(vt[i].eo));
        chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vt[i].er));
        if (vt[i].cd)
          chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vt[i].ed));
        if (vt[i].cu)
          chk($sformatf("v%0d out_data_u", i), 32'(out_data_u), 32'(vt[i].eu));
      end
    end

    // clear while FULL with a word offered in the same cycle
    drive(0,0,1,2'b01,0);
    chk("clr fill0 occ", 32'(occupancy), 32'd0);
    drive(0,0,1,2'b10,0);
    chk("clr fill1 occ", 32'(occupancy), 32'd1);
    drive(0,1,1,2'b11,0);
    chk("clr full occ", 32'(occupancy), 32'd2);
    chk("clr in_ready", 32'(in_ready), 32'd0);
    drive(0,0,0,2'b00,1);
    chk("clr after occ", 32'(occupancy), 32'd0);
    chk("clr after valid", 32'(out_valid), 32'd0);
    chk("clr after ready", 32'(in_ready), 32'd1);
    drive(0,0,0,2'b00,1);
    chk("clr no stale", 32'(out_valid), 32'd0);
    drive(0,0,1,2'b11,1);
    chk("clr idle valid", 32'(out_valid), 32'd0);
    drive(0,0,0,2'b00,1);
    chk("clr new valid", 32'(out_valid), 32'd1);
    chk("clr new data", 32'(out_data), 32'h1f);
    chk("clr new occ", 32'(occupancy), 32'd1);
    drive(0,0,0,2'b00,1);
    chk("clr drained", 32'(out_valid), 32'd0);

    // rst while FULL with out_ready high
    drive(0,0,1,2'b01,0);
    drive(0,0,1,2'b10,0);
    chk("rst fill data", 32'(out_data), 32'h01);
    drive(1,0,0,2'b00,1);
    chk("rst occ full", 32'(occupancy), 32'd2);
    chk("rst deliver valid", 32'(out_valid), 32'd1);
    chk("rst deliver data", 32'(out_data), 32'h01);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    drive(0,0,0,2'b00,0);
    chk("rst occ", 32'(occupancy), 32'd0);
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst data", 32'(out_data), 32'd0);
    chk("rst data_u", 32'(out_data_u), 32'd0);
    chk("rst ready", 32'(in_ready), 32'd1);
    drive(0,0,1,2'b01,1);
    drive(0,0,0,2'b00,1);
    chk("rst new valid", 32'(out_valid), 32'd1);
    chk("rst new data", 32'(out_data), 32'h01);
    chk("rst new occ", 32'(occupancy), 32'd1);
    drive(0,0,0,2'b00,1);
    chk("rst alone valid", 32'(out_valid), 32'd0);
    chk("rst alone occ", 32'(occupancy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/skid_reg_slice.md
Name: skid_reg_slice

Overview:
Two-entry ready/valid register slice (skid buffer) that sits directly upstream of a reset-able output register stage and feeds it.
- Accepts a narrow unsigned or signed input word and delivers it width-adapted (sign- or zero-extended, or truncated) to the downstream stage.
- in_ready is derived only from the slice's state register and the clear/rst inputs, so the upstream input handshake path is broken.
- The output data value is always driven from a register.
- Supports a synchronous flush (clear) for pipeline restart.

Parameters:
IN_WIDTH, 2, width of in_data in bits (>=1).
OUT_WIDTH, 5, width of out_data in bits (>=1).
SIGNED, 1, 1 = sign-extend in_data when OUT_WIDTH > IN_WIDTH; 0 = zero-extend.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
clear  input  1  synchronous flush; empties both entries.
in_valid  input  1  upstream word valid.
in_ready  output  1  slice can accept a word this cycle.
in_data  input  IN_WIDTH  upstream word.
out_valid  output  1  out_data holds a valid word.
out_ready  input  1  downstream accepts the word this cycle.
out_data  output  OUT_WIDTH  width-adapted word (reg-driven).
occupancy  output  2  number of held words (0, 1 or 2).

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst); no asynchronous paths.
- Reset values (visible the cycle after rst sampled high):
  - state = EMPTY, out_valid = 0, out_data = 0, occupancy = 0.
  - Skid register = 0.
- in_ready = !rst && !clear && (state != FULL). It is 1 in the first cycle after reset deasserts.
- Accept = in_valid && in_ready. Deliver = out_valid && out_ready.
- Width rule, applied when a word is captured:
  - OUT_WIDTH > IN_WIDTH: extend (sign if SIGNED=1, else zero).
  - OUT_WIDTH == IN_WIDTH: pass through.
  - OUT_WIDTH < IN_WIDTH: keep the low OUT_WIDTH bits.
  - Both the out register and the skid register store the already-adapted OUT_WIDTH value.
- States: EMPTY (occ 0), BUSY (occ 1, word in out register), FULL (occ 2, out register plus skid register).
- EMPTY:
  - Accept: out_data <= adapt(in_data), go to BUSY.
  - Otherwise stay.
- BUSY:
  - Accept and Deliver: out_data <= adapt(in_data), stay BUSY.
  - Accept and no Deliver: skid <= adapt(in_data), go to FULL.
  - Deliver only: go to EMPTY. out_data holds its last value; it is don't-care to consumers but must not be X.
  - Neither: hold.
- FULL:
  - in_ready = 0.
  - Deliver: out_data <= skid, go to BUSY.
  - Otherwise hold.
- Latency and ordering:
  - Minimum latency in_valid -> out_valid is 1 cycle.
  - Full throughput is 1 word/cycle when out_ready stays high.
  - Word order is strictly preserved; no word is dropped or duplicated.
- clear:
  - Next state = EMPTY; out_valid = 0 next cycle; occupancy = 0.
  - in_ready = 0 in the clear cycle, so no word is accepted.
  - A Deliver in the same cycle is still a valid transfer downstream.
  - Data registers are not required to be zeroed.
- rst has priority over clear, and clear over any handshake.
- rst asserted mid-transfer: all held words are discarded. Behaviour is identical to power-on reset the cycle after.
- out_valid must not deassert without a Deliver, except under clear or rst.
- occupancy equals the state encoding (EMPTY=0, BUSY=1, FULL=2), registered.

Decomposition:
- Shared package skid_pkg:
  - State enum skid_state_t {EMPTY=2'd0, BUSY=2'd1, FULL=2'd2}, used directly as occupancy.
  - Constant for the width of occupancy.
- One combinational sub-module, width_adapt (parameters IN_WIDTH, OUT_WIDTH, SIGNED).
  - Performs extension or truncation.
  - Is reused by the downstream output-register stage and by verification as its reference model.

Test Plan:
1. Reset and sign extension. rst held 2 cycles, then released: out_valid=0, occupancy=0, in_ready=1. Then in_data=2'b10, in_valid=1 for one cycle with out_ready=1: next cycle out_valid=1, out_data=5'b11110.
2. Zero extension. SIGNED=0, in_data=2'b10: out_data=5'b00010. SIGNED=1, in_data=2'b01: out_data=5'b00001.
3. Backpressure fill:
   - Send 2'b01 then 2'b11 with out_ready=0: occupancy goes 1 then 2; in_ready=0 while occupancy is 2.
   - Raise out_ready: delivers 5'b00001 then 5'b11111 in order.
   - Then occupancy=0.
4. Streaming. in_valid=1 and out_ready=1 every cycle with data sequence 0,1,2,3: one word delivered per cycle, 1-cycle latency, occupancy stays 1, in_ready never drops.
5. clear while FULL, with in_valid=1 in the same cycle: next cycle occupancy=0 and out_valid=0. The offered word is not accepted (in_ready was 0) and no stale word appears afterwards.
6. rst asserted while FULL with out_ready=1: that cycle's Deliver counts. The next cycle shows the reset values, and a subsequent new word emerges alone with correct data.
